// File: rtl/bs_pkg.sv
// Shared command codes, state encoding and default sizing for the sample sequencer.
package bs_pkg;

   localparam int unsigned LATENCY_DEF = 50;
   localparam int unsigned CNT_W_DEF   = 32;

   localparam logic [3:0] CMD_RUN   = 4'd1;
   localparam logic [3:0] CMD_ACK   = 4'd2;
   localparam logic [3:0] CMD_ABORT = 4'd3;

   // Encoding is visible on the status port, so the values are fixed.
   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StRunning  = 4'd1,
      StComplete = 4'd2,
      StLoad     = 4'd3,
      StDrain    = 4'd4
   } state_e;

endpackage

// File: rtl/bs_valid_pipe.sv
// Valid-bit delay line that mirrors the datapath latency; the last stage flags a result.
module bs_valid_pipe #(
   parameter int unsigned LATENCY = bs_pkg::LATENCY_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic valid_in,
   output logic valid_out
);

   logic [LATENCY-1:0] sr_q, sr_d;

   // Shift in one stage per cycle; the oldest bit falls off the top.
   always_comb begin
      sr_d = LATENCY'({sr_q, valid_in});
   end

   // Delay-line register; reset flushes anything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign valid_out = sr_q[LATENCY-1];

endmodule

// File: rtl/bs_seq_ctrl.sv
// Sample sequencer: issues GRN samples into the datapath and tracks their retirement.
module bs_seq_ctrl
   import bs_pkg::*;
#(
   parameter int unsigned LATENCY = LATENCY_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       cmd,
   input  logic [CNT_W-1:0] niter,
   input  logic             grn_valid,
   output logic             grn_ready,
   output logic             issue_valid,
   output logic             cfg_load,
   output logic             acc_clr,
   output logic             acc_en,
   output logic [3:0]       status,
   output logic             aborted,
   output logic [CNT_W-1:0] issued_cnt,
   output logic [CNT_W-1:0] retired_cnt
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             aborted_q, aborted_d;

   logic abort_req;
   logic issue_room;

   assign abort_req  = (cmd == CMD_ABORT);
   assign issue_room = (issued_q < target_q);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; commands outside their owning state are ignored.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (cmd == CMD_RUN) state_d = StLoad;
         StLoad:     state_d = StRunning;
         StRunning:  if (abort_req || !issue_room) state_d = StDrain;
         StDrain:    if (retired_q == issued_q) state_d = StComplete;
         StComplete: if (cmd == CMD_ACK) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Control strobes; an ABORT suppresses issue in the cycle it arrives.
   always_comb begin
      issue_valid = (state_q == StRunning) && grn_valid && issue_room && !abort_req;
      grn_ready   = issue_valid;
      cfg_load    = (state_q == StLoad);
      acc_clr     = (state_q == StLoad);
      status      = state_q;
   end

   // Run bookkeeping: target capture, issue/retire counts and abort flag.
   always_comb begin
      target_d  = target_q;
      issued_d  = issued_q;
      retired_d = retired_q;
      aborted_d = aborted_q;
      if ((state_q == StIdle) && (cmd == CMD_RUN)) begin
         target_d = niter;
      end
      if (state_q == StLoad) begin
         issued_d  = '0;
         retired_d = '0;
         aborted_d = 1'b0;
      end else begin
         if (issue_valid) begin
            issued_d = issued_q + CNT_W'(1);
         end
         // Guard keeps retired_cnt from ever passing issued_cnt.
         if (acc_en && (retired_q < issued_q)) begin
            retired_d = retired_q + CNT_W'(1);
         end
         if ((state_q == StRunning) && abort_req) begin
            aborted_d = 1'b1;
         end
      end
   end

   // Bookkeeping registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         target_q  <= '0;
         issued_q  <= '0;
         retired_q <= '0;
         aborted_q <= 1'b0;
      end else begin
         target_q  <= target_d;
         issued_q  <= issued_d;
         retired_q <= retired_d;
         aborted_q <= aborted_d;
      end
   end

   assign aborted     = aborted_q;
   assign issued_cnt  = issued_q;
   assign retired_cnt = retired_q;

   bs_valid_pipe #(
      .LATENCY(LATENCY)
   ) u_valid_pipe (
      .clk      (clk),
      .reset    (reset),
      .valid_in (issue_valid),
      .valid_out(acc_en)
   );

endmodule

// File: doc/bs_seq_ctrl.md
BS_SEQ_CTRL -- requirements
Module: bs_seq_ctrl

Interface
REQ-001 Parameter LATENCY, default 50: cycles from issue_valid to the matching result at the datapath accumulator input; legal range 1..255.
REQ-002 Parameter CNT_W, default 32: width of iteration counters.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd  input  4  command: 1 = RUN, 2 = ACK, 3 = ABORT; other values are no-op.
REQ-006 niter  input  CNT_W  requested sample count; sampled in IDLE.
REQ-007 grn_valid  input  1  Gaussian random number available this cycle.
REQ-008 grn_ready  output  1  pop strobe to the GRN source; equal to issue_valid.
REQ-009 issue_valid  output  1  a sample enters the datapath this cycle.
REQ-010 cfg_load  output  1  one-cycle strobe; datapath latches constK/const1/const2.
REQ-011 acc_clr  output  1  one-cycle strobe clearing sum and pow_sum.
REQ-012 acc_en  output  1  result at the datapath exit is valid and shall be accumulated.
REQ-013 status  output  4  current state code.
REQ-014 aborted  output  1  the last run ended through ABORT.
REQ-015 issued_cnt, retired_cnt  output  CNT_W each  samples issued / retired in the current run.

Function
REQ-016 State codes: IDLE = 0, RUNNING = 1, COMPLETE = 2, LOAD = 3, DRAIN = 4; status shall equal the state register.
REQ-017 IDLE: cmd = RUN registers niter into target and moves to LOAD; any other cmd stays in IDLE.
REQ-018 LOAD: lasts exactly one cycle, asserts cfg_load and acc_clr, zeroes both counters and aborted, then moves to RUNNING.
REQ-019 RUNNING: issue_valid = grn_valid AND (issued_cnt < target), combinationally; issued_cnt increments on each issue.
REQ-020 RUNNING moves to DRAIN in the cycle after issued_cnt reaches target.
REQ-021 A LATENCY-bit valid shift register shifts every cycle with issue_valid as input; acc_en is its last stage, so acc_en is asserted exactly LATENCY cycles after each issue_valid.
REQ-022 retired_cnt increments on every acc_en.
REQ-023 DRAIN: no issue; moves to COMPLETE in the cycle after retired_cnt equals issued_cnt.
REQ-024 COMPLETE: holds until cmd = ACK, then moves to IDLE; RUN and ABORT are ignored.
REQ-025 ABORT in RUNNING: issuing stops in that same cycle, aborted is set, and the state moves to DRAIN; ABORT in other states is ignored.
REQ-026 niter = 0: LOAD, then one RUNNING cycle with no issue, then DRAIN, then COMPLETE with zero acc_en pulses.
REQ-027 grn_valid low in RUNNING stalls issue only; in-flight results keep retiring.
REQ-028 A change of niter or cmd outside IDLE does not affect the active run.
REQ-029 Counters do not wrap: issued_cnt never exceeds target, and retired_cnt never exceeds issued_cnt.

Reset
REQ-030 Reset forces state = IDLE, clears the shift register, counters, target and aborted, and drives every strobe output low, independent of clk.
REQ-031 Reset mid-run discards in-flight samples; acc_en stays low until a new issue has traversed LATENCY stages.

Structure
REQ-032 A shared package bs_pkg holds the cmd codes, state codes, LATENCY default and CNT_W.
REQ-033 The valid shift register is a separate sub-module bs_valid_pipe, parameterized by LATENCY.
REQ-034 The block drives no datapath arithmetic; it only produces control strobes.

Verification (LATENCY = 4)
REQ-035 RUN with niter = 5 and grn_valid held high: exactly 5 consecutive issue_valid cycles; acc_en pulses 4 cycles after each; COMPLETE is reached with retired_cnt = 5.
REQ-036 niter = 6 with grn_valid toggling 1,0,1,0: 6 issues spread over 11 cycles; acc_en pattern equals the issue pattern delayed by 4.
REQ-037 niter = 0: status sequence 0,3,1,4,2; no issue_valid or acc_en; cfg_load and acc_clr pulse once.
REQ-038 niter = 100, ABORT after 10 issues: issued_cnt = 10, retired_cnt = 10, aborted = 1, COMPLETE; then ACK returns status to 0.
REQ-039 Reset asserted after 3 issues: status = 0 and all outputs 0 immediately; no acc_en pulses within the following 10 cycles.
REQ-040 RUN held during COMPLETE: the state stays at 2; ACK returns it to IDLE, and a new RUN with niter = 2 then yields 2 issues.
